// File: rtl/rv32_pkg.sv
// Shared RV32I decode constants: opcodes, funct7 values, immediate/writeback
// encodings and the registered control bundle handed to execute.
package rv32_pkg;

   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   localparam int unsigned ALU_OP_W = 5;

   typedef enum logic [2:0] {
      IMM_R = 3'b000,
      IMM_I = 3'b001,
      IMM_S = 3'b010,
      IMM_B = 3'b011,
      IMM_U = 3'b100,
      IMM_J = 3'b101
   } imm_type_e;

   typedef enum logic [2:0] {
      WB_ALU    = 3'b000,
      WB_LOAD   = 3'b001,
      WB_IMM    = 3'b010,
      WB_IADDER = 3'b011,
      WB_PC4    = 3'b100
   } wb_sel_e;

   typedef struct packed {
      logic [4:0]          rs1;
      logic [4:0]          rs2;
      logic [4:0]          rd;
      logic [ALU_OP_W-1:0] alu_opcode;
      imm_type_e           imm_type;
      wb_sel_e             wb_mux_sel;
      logic                alu_src;
      logic                iadder_src;
      logic                mem_wr_req;
      logic [1:0]          load_size;
      logic                load_unsigned;
      logic                rf_wr_en;
      logic                branch;
      logic                jump;
      logic                illegal;
   } dec_ctrl_t;

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake plus decoded bundle of the decode stage.
interface decode_stage_if #(
   parameter int unsigned PC_WIDTH = 32
);
   logic                valid_in;
   logic                ready_out;
   logic [31:0]         instr_in;
   logic [PC_WIDTH-1:0] pc_in;
   logic                valid_out;
   logic                ready_in;
   logic [PC_WIDTH-1:0] pc_out;
   logic [4:0]          rs1_addr_out;
   logic [4:0]          rs2_addr_out;
   logic [4:0]          rd_addr_out;
   logic [4:0]          alu_opcode_out;
   logic [2:0]          imm_type_out;
   logic [2:0]          wb_mux_sel_out;
   logic                alu_src_out;
   logic                iadder_src_out;
   logic                mem_wr_req_out;
   logic [1:0]          load_size_out;
   logic                load_unsigned_out;
   logic                rf_wr_en_out;
   logic                branch_out;
   logic                jump_out;
   logic                illegal_out;

   modport slave (
      input  valid_in, instr_in, pc_in, ready_in,
      output ready_out, valid_out, pc_out, rs1_addr_out, rs2_addr_out, rd_addr_out,
             alu_opcode_out, imm_type_out, wb_mux_sel_out, alu_src_out, iadder_src_out,
             mem_wr_req_out, load_size_out, load_unsigned_out, rf_wr_en_out,
             branch_out, jump_out, illegal_out
   );

   modport master (
      output valid_in, instr_in, pc_in, ready_in,
      input  ready_out, valid_out, pc_out, rs1_addr_out, rs2_addr_out, rd_addr_out,
             alu_opcode_out, imm_type_out, wb_mux_sel_out, alu_src_out, iadder_src_out,
             mem_wr_req_out, load_size_out, load_unsigned_out, rf_wr_en_out,
             branch_out, jump_out, illegal_out
   );
endinterface

// File: rtl/decode_logic.sv
// Combinational RV32I(+M) decoder: instruction word to control bundle and
// illegal flag; illegal encodings have every side-effect enable cleared.
module decode_logic
   import rv32_pkg::*;
#(
   parameter bit HAS_M = 1'b0
) (
   input  logic [31:0] instr_i,
   output dec_ctrl_t   ctrl_o
);

   logic [6:0] opc;
   logic [2:0] f3;
   logic [6:0] f7;
   logic       legal;

   assign opc = instr_i[6:0];
   assign f3  = instr_i[14:12];
   assign f7  = instr_i[31:25];

   always_comb begin
      ctrl_o               = '0;
      legal                = 1'b1;
      ctrl_o.rs1           = instr_i[19:15];
      ctrl_o.rs2           = instr_i[24:20];
      ctrl_o.rd            = instr_i[11:7];
      ctrl_o.alu_opcode    = {2'b00, f3};
      ctrl_o.alu_src       = instr_i[5];
      ctrl_o.load_size     = f3[1:0];
      ctrl_o.load_unsigned = f3[2];

      case (opc)
         OPC_LOAD: begin
            ctrl_o.imm_type   = IMM_I;
            ctrl_o.wb_mux_sel = WB_LOAD;
            ctrl_o.iadder_src = 1'b1;
            ctrl_o.rf_wr_en   = 1'b1;
            legal             = (f3 != 3'b011) && (f3[2:1] != 2'b11);
         end
         OPC_STORE: begin
            ctrl_o.imm_type   = IMM_S;
            ctrl_o.iadder_src = 1'b1;
            ctrl_o.mem_wr_req = 1'b1;
            legal             = (f3 < 3'b011);
         end
         OPC_OP: begin
            ctrl_o.imm_type      = IMM_R;
            ctrl_o.wb_mux_sel    = WB_ALU;
            ctrl_o.rf_wr_en      = 1'b1;
            ctrl_o.alu_opcode[4] = HAS_M && (f7 == F7_MULDIV);
            ctrl_o.alu_opcode[3] = f7[5];
            legal = (f7 == F7_BASE)
                 || ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)))
                 || (HAS_M && (f7 == F7_MULDIV));
         end
         OPC_OP_IMM: begin
            ctrl_o.imm_type = IMM_I;
            ctrl_o.rf_wr_en = 1'b1;
            // funct7 only carries meaning for the shift-immediate forms
            if (f3 == 3'b101) begin
               ctrl_o.alu_opcode[3] = f7[5];
               legal = (f7 == F7_BASE) || (f7 == F7_ALT);
            end else if (f3 == 3'b001) begin
               legal = (f7 == F7_BASE);
            end
         end
         OPC_LUI: begin
            ctrl_o.imm_type   = IMM_U;
            ctrl_o.wb_mux_sel = WB_IMM;
            ctrl_o.rf_wr_en   = 1'b1;
         end
         OPC_AUIPC: begin
            ctrl_o.imm_type   = IMM_U;
            ctrl_o.wb_mux_sel = WB_IADDER;
            ctrl_o.rf_wr_en   = 1'b1;
         end
         OPC_JAL: begin
            ctrl_o.imm_type   = IMM_J;
            ctrl_o.wb_mux_sel = WB_PC4;
            ctrl_o.rf_wr_en   = 1'b1;
            ctrl_o.jump       = 1'b1;
         end
         OPC_JALR: begin
            ctrl_o.imm_type   = IMM_I;
            ctrl_o.wb_mux_sel = WB_PC4;
            ctrl_o.iadder_src = 1'b1;
            ctrl_o.rf_wr_en   = 1'b1;
            ctrl_o.jump       = 1'b1;
            legal             = (f3 == 3'b000);
         end
         OPC_BRANCH: begin
            ctrl_o.imm_type = IMM_B;
            ctrl_o.branch   = 1'b1;
            legal           = (f3[2:1] != 2'b01);
         end
         OPC_MISC_MEM, OPC_SYSTEM: begin
            ctrl_o.imm_type = IMM_I;
         end
         default: legal = 1'b0;
      endcase

      if ((instr_i == '0) || (instr_i == '1)) legal = 1'b0;

      ctrl_o.illegal = ~legal;
      if (!legal) begin
         ctrl_o.rf_wr_en   = 1'b0;
         ctrl_o.mem_wr_req = 1'b0;
         ctrl_o.branch     = 1'b0;
         ctrl_o.jump       = 1'b0;
      end
   end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: one pipeline register with valid/ready on both
// sides, flush that wins over a simultaneous load, and async reset.
module decode_stage
   import rv32_pkg::*;
#(
   parameter int unsigned PC_WIDTH = 32,
   parameter bit          HAS_M    = 1'b0
) (
   input  logic          clk_in,
   input  logic          rst_in,
   input  logic          flush_in,
   decode_stage_if.slave bus
);

   dec_ctrl_t           dec;
   dec_ctrl_t           ctrl_q;
   logic [PC_WIDTH-1:0] pc_q;
   logic                valid_q;
   logic                valid_d;
   logic                ready;
   logic                load;

   decode_logic #(.HAS_M(HAS_M)) u_decode_logic (
      .instr_i (bus.instr_in),
      .ctrl_o  (dec)
   );

   assign ready = ~valid_q | bus.ready_in;
   assign load  = bus.valid_in & ready;

   always_comb begin
      valid_d = valid_q;
      if (flush_in)          valid_d = 1'b0;
      else if (load)         valid_d = 1'b1;
      else if (bus.ready_in) valid_d = 1'b0;
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         valid_q <= 1'b0;
         ctrl_q  <= '0;
         pc_q    <= '0;
      end else begin
         valid_q <= valid_d;
         if (load && !flush_in) begin
            ctrl_q <= dec;
            pc_q   <= bus.pc_in;
         end
      end
   end

   assign bus.ready_out         = ready;
   assign bus.valid_out         = valid_q;
   assign bus.pc_out            = pc_q;
   assign bus.rs1_addr_out      = ctrl_q.rs1;
   assign bus.rs2_addr_out      = ctrl_q.rs2;
   assign bus.rd_addr_out       = ctrl_q.rd;
   assign bus.alu_opcode_out    = ctrl_q.alu_opcode;
   assign bus.imm_type_out      = ctrl_q.imm_type;
   assign bus.wb_mux_sel_out    = ctrl_q.wb_mux_sel;
   assign bus.alu_src_out       = ctrl_q.alu_src;
   assign bus.iadder_src_out    = ctrl_q.iadder_src;
   assign bus.mem_wr_req_out    = ctrl_q.mem_wr_req;
   assign bus.load_size_out     = ctrl_q.load_size;
   assign bus.load_unsigned_out = ctrl_q.load_unsigned;
   assign bus.rf_wr_en_out      = ctrl_q.rf_wr_en;
   assign bus.branch_out        = ctrl_q.branch;
   assign bus.jump_out          = ctrl_q.jump;
   assign bus.illegal_out       = ctrl_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed vector table, stall/flush/reset sequences,
// and random traffic against an instruction-class reference model.
module tb_decode_stage;

   typedef struct packed {
      logic [4:0] rs1, rs2, rd, alu;
      logic [2:0] imm, wb;
      logic       alu_src, iadd, mem;
      logic [1:0] lsize;
      logic       lun, rfwr, br, jmp, ill;
   } exp_t;

   typedef struct {
      logic [31:0] ins;
      logic [4:0]  alu;
      logic [2:0]  imm, wb;
      logic        rfwr, alusrc, ill, br;
      logic [4:0]  rd;
   } vec_t;

   typedef enum int {K_LOAD, K_STORE, K_OP, K_OPIMM, K_LUI, K_AUIPC, K_JAL,
                     K_JALR, K_BRANCH, K_MISC, K_SYS, K_BAD} kind_e;

   localparam logic [6:0] OPC_LIST [11] = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h37,
                                            7'h17, 7'h6F, 7'h67, 7'h63, 7'h0F, 7'h73};

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic flush = 1'b0;
   int   total = 0;
   int   bad = 0;

   bit   m_valid = 1'b0;
   exp_t m_b0, m_b1;
   logic [31:0] m_pc;

   always #5 clk = ~clk;

   decode_stage_if #(.PC_WIDTH(32)) dif0 ();
   decode_stage_if #(.PC_WIDTH(32)) dif1 ();

   decode_stage #(.PC_WIDTH(32), .HAS_M(1'b0)) dut0 (
      .clk_in(clk), .rst_in(rst), .flush_in(flush), .bus(dif0));
   decode_stage #(.PC_WIDTH(32), .HAS_M(1'b1)) dut1 (
      .clk_in(clk), .rst_in(rst), .flush_in(flush), .bus(dif1));

   function automatic exp_t ref_decode(logic [31:0] ins, bit has_m);
      exp_t        e;
      kind_e       k;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [7:0]  okmask;
      bit          ok, wr, mem, br, jmp;
      f3 = ins[14:12];
      f7 = ins[31:25];
      k  = K_BAD;
      for (int i = 0; i < 11; i++) if (ins[6:0] == OPC_LIST[i]) k = kind_e'(i);
      e = '0;
      e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
      e.alu_src = ins[5]; e.lsize = ins[13:12]; e.lun = ins[14];
      ok = 1; wr = 0; mem = 0; br = 0; jmp = 0;
      okmask = 8'hFF;
      case (k)
         K_LOAD:   begin e.imm = 1; e.wb = 1; e.iadd = 1; wr = 1; okmask = 8'h37; end
         K_STORE:  begin e.imm = 2; e.iadd = 1; mem = 1; okmask = 8'h07; end
         K_OP: begin
            wr = 1;
            ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 0 || f3 == 5)) || (f7 == 7'h01 && has_m);
         end
         K_OPIMM: begin
            e.imm = 1; wr = 1;
            if (f3 == 1) ok = (f7 == 7'h00);
            if (f3 == 5) ok = (f7 == 7'h00) || (f7 == 7'h20);
         end
         K_LUI:    begin e.imm = 4; e.wb = 2; wr = 1; end
         K_AUIPC:  begin e.imm = 4; e.wb = 3; wr = 1; end
         K_JAL:    begin e.imm = 5; e.wb = 4; wr = 1; jmp = 1; end
         K_JALR:   begin e.imm = 1; e.wb = 4; e.iadd = 1; wr = 1; jmp = 1; okmask = 8'h01; end
         K_BRANCH: begin e.imm = 3; br = 1; okmask = 8'hF3; end
         K_MISC, K_SYS: e.imm = 1;
         default:  ok = 0;
      endcase
      if (okmask[f3] == 1'b0) ok = 0;
      if (ins == 32'h0 || ins == 32'hFFFF_FFFF) ok = 0;
      e.alu  = {has_m && k == K_OP && f7 == 7'h01,
                (k == K_OP || (k == K_OPIMM && f3 == 3'd5)) && ins[30], f3};
      e.ill  = !ok;
      e.rfwr = wr && ok; e.mem = mem && ok; e.br = br && ok; e.jmp = jmp && ok;
      return e;
   endfunction

   function automatic exp_t out0();
      return '{rs1: dif0.rs1_addr_out, rs2: dif0.rs2_addr_out, rd: dif0.rd_addr_out,
               alu: dif0.alu_opcode_out, imm: dif0.imm_type_out, wb: dif0.wb_mux_sel_out,
               alu_src: dif0.alu_src_out, iadd: dif0.iadder_src_out, mem: dif0.mem_wr_req_out,
               lsize: dif0.load_size_out, lun: dif0.load_unsigned_out, rfwr: dif0.rf_wr_en_out,
               br: dif0.branch_out, jmp: dif0.jump_out, ill: dif0.illegal_out};
   endfunction

   function automatic exp_t out1();
      return '{rs1: dif1.rs1_addr_out, rs2: dif1.rs2_addr_out, rd: dif1.rd_addr_out,
               alu: dif1.alu_opcode_out, imm: dif1.imm_type_out, wb: dif1.wb_mux_sel_out,
               alu_src: dif1.alu_src_out, iadd: dif1.iadder_src_out, mem: dif1.mem_wr_req_out,
               lsize: dif1.load_size_out, lun: dif1.load_unsigned_out, rfwr: dif1.rf_wr_en_out,
               br: dif1.branch_out, jmp: dif1.jump_out, ill: dif1.illegal_out};
   endfunction

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic drive(bit v, logic [31:0] ins, logic [31:0] pc, bit rdy, bit fl);
      dif0.valid_in = v; dif0.instr_in = ins; dif0.pc_in = pc; dif0.ready_in = rdy;
      dif1.valid_in = v; dif1.instr_in = ins; dif1.pc_in = pc; dif1.ready_in = rdy;
      flush = fl;
   endtask

   // Called at a negedge; returns at the following negedge with outputs checked.
   task automatic step(bit v, logic [31:0] ins, logic [31:0] pc, bit rdy, bit fl);
      bit exp_ready;
      drive(v, ins, pc, rdy, fl);
      #1;
      exp_ready = !m_valid || rdy;
      chk("ready_out0", 64'(dif0.ready_out), 64'(exp_ready));
      chk("ready_out1", 64'(dif1.ready_out), 64'(exp_ready));
      @(posedge clk);
      if (fl) m_valid = 0;
      else if (v && exp_ready) begin
         m_valid = 1; m_pc = pc;
         m_b0 = ref_decode(ins, 1'b0);
         m_b1 = ref_decode(ins, 1'b1);
      end else if (rdy) m_valid = 0;
      @(negedge clk);
      chk("valid_out0", 64'(dif0.valid_out), 64'(m_valid));
      chk("valid_out1", 64'(dif1.valid_out), 64'(m_valid));
      if (m_valid) begin
         chk("bundle0", 64'(out0()), 64'(m_b0));
         chk("bundle1", 64'(out1()), 64'(m_b1));
         chk("pc_out0", 64'(dif0.pc_out), 64'(m_pc));
         chk("pc_out1", 64'(dif1.pc_out), 64'(m_pc));
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        tv[12];
      logic [31:0] r, ins;
      logic [6:0]  f7;
      tv[0]  = '{32'h00510093, 5'b00000, 3'b001, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1};
      tv[1]  = '{32'h402081B3, 5'b01000, 3'b000, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 5'd3};
      tv[2]  = '{32'h027302B3, 5'b00000, 3'b000, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 5'd5};
      tv[3]  = '{32'h0000A103, 5'b00010, 3'b001, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 5'd2};
      tv[4]  = '{32'h40505013, 5'b01101, 3'b001, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0};
      tv[5]  = '{32'h000010B7, 5'b00001, 3'b100, 3'b010, 1'b1, 1'b1, 1'b0, 1'b0, 5'd1};
      tv[6]  = '{32'h0000006F, 5'b00000, 3'b101, 3'b100, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0};
      tv[7]  = '{32'h00002063, 5'b00010, 3'b011, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0};
      tv[8]  = '{32'h0000000F, 5'b00000, 3'b001, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0};
      tv[9]  = '{32'hFFFFFFFF, 5'b00111, 3'b000, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 5'd31};
      tv[10] = '{32'h00000000, 5'b00000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0};
      tv[11] = '{32'h00000063, 5'b00000, 3'b011, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0};

      drive(0, 32'h0, 32'h0, 1, 0);
      #2;
      chk("reset valid_out", 64'(dif0.valid_out), 64'd0);
      chk("reset ready_out", 64'(dif0.ready_out), 64'd1);
      chk("reset bundle", 64'(out0()), 64'd0);
      chk("reset pc_out", 64'(dif0.pc_out), 64'd0);
      @(negedge clk);
      rst = 0;

      // Directed vectors back to back with ready_in held high
      for (int i = 0; i < 12; i++) begin
         step(1, tv[i].ins, 32'h1000 + 32'(4 * i), 1, 0);
         chk($sformatf("vec%0d", i),
             64'({dif0.valid_out, dif0.alu_opcode_out, dif0.imm_type_out, dif0.wb_mux_sel_out,
                  dif0.rf_wr_en_out, dif0.alu_src_out, dif0.illegal_out, dif0.branch_out,
                  dif0.rd_addr_out}),
             64'({1'b1, tv[i].alu, tv[i].imm, tv[i].wb, tv[i].rfwr, tv[i].alusrc,
                  tv[i].ill, tv[i].br, tv[i].rd}));
      end

      step(1, 32'h027302B3, 32'h2000, 1, 0);
      chk("mul HAS_M=1", 64'({dif1.alu_opcode_out, dif1.illegal_out, dif1.rf_wr_en_out}),
          64'({5'b10000, 1'b0, 1'b1}));
      chk("mul HAS_M=0", 64'({dif0.illegal_out, dif0.rf_wr_en_out}), 64'({1'b1, 1'b0}));

      // Stall: lw held three cycles while addi waits
      step(1, 32'h0000A103, 32'h3000, 1, 0);
      for (int i = 0; i < 3; i++) begin
         step(1, 32'h00510093, 32'h3004, 0, 0);
         chk("stall hold", 64'({dif0.valid_out, dif0.ready_out, dif0.rd_addr_out, dif0.pc_out}),
             64'({1'b1, 1'b0, 5'd2, 32'h3000}));
      end
      chk("lw fields", 64'({dif0.wb_mux_sel_out, dif0.load_size_out, dif0.iadder_src_out}),
          64'({3'b001, 2'b10, 1'b1}));
      step(1, 32'h00510093, 32'h3004, 1, 0);
      chk("after stall", 64'({dif0.valid_out, dif0.rd_addr_out, dif0.pc_out}),
          64'({1'b1, 5'd1, 32'h3004}));

      // Flush with a held bundle and a valid incoming instruction
      step(1, 32'h402081B3, 32'h4000, 0, 0);
      step(1, 32'h402081B3, 32'h4000, 0, 1);
      chk("flush valid_out", 64'(dif0.valid_out), 64'd0);
      step(0, 32'h0, 32'h0, 1, 0);

      // Reset together with flush in the middle of a stall
      step(1, 32'h0000A103, 32'h5000, 1, 0);
      step(0, 32'h0, 32'h0, 0, 0);
      rst = 1; flush = 1;
      #1;
      chk("async reset valid", 64'({dif0.valid_out, dif1.valid_out}), 64'd0);
      chk("async reset ready", 64'(dif0.ready_out), 64'd1);
      chk("async reset rd", 64'(dif0.rd_addr_out), 64'd0);
      m_valid = 0;
      @(posedge clk);
      @(negedge clk);
      rst = 0; flush = 0;

      for (int n = 0; n < 400; n++) begin
         r = $urandom;
         case ($urandom_range(0, 19))
            0: ins = r;
            1: ins = r[0] ? 32'hFFFF_FFFF : 32'h0;
            default: begin
               case ($urandom_range(0, 3))
                  0: f7 = 7'h00;
                  1: f7 = 7'h20;
                  2: f7 = 7'h01;
                  default: f7 = r[31:25];
               endcase
               ins = {f7, r[24:7], OPC_LIST[$urandom_range(0, 10)]};
            end
         endcase
         step($urandom_range(0, 3) != 0, ins, $urandom,
              $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Registered, parametrised RV32I instruction decode stage with a valid/ready handshake on both sides, a flush input and illegal-instruction detection. It takes the full 32-bit instruction and PC from fetch and presents registered control fields, register addresses and PC to the execute stage. It optionally decodes the M extension, controlled by HAS_M. It adds pipelining, back-pressure and legality checking to the control encodings the core already uses.

Parameters:
PC_WIDTH, 32, width of pc_in/pc_out
HAS_M, 0, 1 = decode MUL/DIV (OP with funct7=0000001); 0 = flag them illegal

Ports:
clk_in  in  1  core clock, rising edge
rst_in  in  1  asynchronous reset, active-high
flush_in  in  1  kill held and incoming instruction
valid_in  in  1  fetch presents instruction
ready_out  out  1  stage accepts this cycle
instr_in  in  32  instruction word
pc_in  in  PC_WIDTH  instruction PC
valid_out  out  1  decoded bundle valid
ready_in  in  1  execute accepts bundle
pc_out  out  PC_WIDTH  registered PC
rs1_addr_out / rs2_addr_out / rd_addr_out  out  5 each  instr[19:15] / [24:20] / [11:7]
alu_opcode_out  out  5  {muldiv, funct7_5 gated, funct3}
imm_type_out  out  3  000 R, 001 I, 010 S, 011 B, 100 U, 101 J
wb_mux_sel_out  out  3  000 ALU, 001 load, 010 imm (LUI), 011 iadder (AUIPC), 100 PC+4 (JAL/JALR)
alu_src_out  out  1  instr[5] (1 = rs2, 0 = imm)
iadder_src_out  out  1  1 = rs1 base (load/store/JALR), 0 = PC
mem_wr_req_out  out  1  store
load_size_out  out  2  funct3[1:0]
load_unsigned_out  out  1  funct3[2]
rf_wr_en_out  out  1  writes rd (rd=0 still asserts)
branch_out / jump_out  out  1 each  BRANCH / JAL|JALR
illegal_out  out  1  illegal encoding

Behaviour:
- One pipeline register. ready_out = ~valid_out | ready_in (combinational). Load occurs when valid_in & ready_out. Latency is 1 cycle; throughput is 1/cycle with ready_in held high.
- valid_out next = flush_in ? 0 : (valid_in & ready_out) ? 1 : (ready_in ? 0 : valid_out).
- flush_in overrides a simultaneous load. The flushed bundle is dropped; fields may hold stale data while valid_out=0.
- Bundle stays stable while valid_out & ~ready_in (no field changes).
- Reset: all outputs 0 (valid_out=0, ready_out=1 after reset). Reset mid-operation drops the held bundle.
- alu_opcode: bit4 = HAS_M & is_OP & funct7==0000001. Bit3 = funct7_5 for OP, and for OP_IMM only when funct3=101 (SRAI); otherwise 0. Bits[2:0] = funct3.
- Legal opcodes (instr[6:0]): LOAD 0000011, STORE 0100011, OP 0110011, OP_IMM 0010011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, MISC_MEM 0001111, SYSTEM 1110011.
- Illegal when any of:
  - instr[1:0] != 11, or unlisted opcode
  - BRANCH funct3 010/011
  - LOAD funct3 011/110/111
  - STORE funct3 >= 011
  - JALR funct3 != 000
  - OP funct7 not 0000000, not 0100000 with funct3 000/101, and not 0000001 with HAS_M=1
  - OP_IMM funct3 001 with funct7 != 0
  - OP_IMM funct3 101 with funct7 not 0000000/0100000
  - instr == 0x00000000 or 0xFFFFFFFF
- Illegal bundles force rf_wr_en, mem_wr_req, branch and jump to 0. They are still passed with valid_out=1 so execute can trap.
- MISC_MEM and SYSTEM are legal NOPs: all enables 0, imm_type 001.

Decomposition:
- Shared package rv32_pkg holds:
  - opcode constants (OPC_LOAD…OPC_SYSTEM)
  - IMM_* and WB_* encodings
  - funct7 constants
  - ALU opcode width constant
- One combinational sub-module, decode_logic (instr -> control fields + illegal), instantiated once.
- The handshake register stays in decode_stage.

Test Plan:
- Reset then 0x00510093 (addi x1,x2,5), ready_in=1 -> next cycle: valid_out=1, rd=1, rs1=2, alu_opcode=00000, imm_type=001, wb=000, rf_wr_en=1, alu_src=0.
- 0x402081B3 (sub x3,x1,x2) -> alu_opcode=01000, imm_type=000, alu_src=1, rf_wr_en=1, illegal=0.
- 0x027302B3 (mul x5,x6,x7): HAS_M=0 -> illegal=1, rf_wr_en=0; HAS_M=1 -> alu_opcode=10000, illegal=0.
- 0x0000A103 (lw x2,0(x1)) with ready_in=0 for 3 cycles -> fields stable, ready_out=0, next instr not taken. Then ready_in=1 -> wb=001, load_size=10, iadder_src=1, followed by next instr one cycle later.
- flush_in asserted with valid_in=1 and a bundle held -> next cycle valid_out=0. Flush plus rst_in mid-stall -> valid_out=0 immediately on reset.
- 0x00000000, then 0x00000063 (beq) -> first illegal=1, second branch_out=1, imm_type=011, wb=000, rf_wr_en=0, back-to-back at 1/cycle.
